add_sequencer: RTL and testbench
================================

ADD_SEQUENCER -- requirements
Module: add_sequencer

Interface
REQ-001 Parameter SLICE_W, default 16: width of the shared adder slice, in bits.
REQ-002 Parameter SLICES, default 4: number of slices per operation, giving an operand width of SLICE_W*SLICES = 64 bits.
REQ-003 Port clk, input, 1: the single clock; all state changes on the rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port start, input, 1: request to begin an addition; sampled on the rising edge.
REQ-006 Port a, input, 64: operand A.
REQ-007 Port b, input, 64: operand B.
REQ-008 Port cin, input, 1: carry into the least significant slice.
REQ-009 Port sum, output, 64: result register.
REQ-010 Port cout, output, 1: carry out of the most significant slice.
REQ-011 Port flag_s, output, 1: sign flag, equal to sum[63].
REQ-012 Port flag_z, output, 1: zero flag, high when sum == 0.
REQ-013 Port flag_p, output, 1: parity flag, high when sum has an even number of ones.
REQ-014 Port flag_ov, output, 1: signed two's-complement overflow.
REQ-015 Port busy, output, 1: high while a slice sequence is running.
REQ-016 Port done, output, 1: single-cycle pulse marking that the result is complete.

Function
REQ-017 The block SHALL contain exactly one SLICE_W-bit adder (a, b, cin in; sum, cout out), time-shared across all slices.
REQ-018 The block SHALL implement the FSM states IDLE, RUN and DONE; the reset state is IDLE.
REQ-019 In IDLE or DONE, start=1 SHALL: latch a, b and cin; set the slice index to 0; enter RUN.
REQ-020 In DONE with start=0, the FSM SHALL return to IDLE on the next edge.
REQ-021 In RUN, each edge SHALL: add slice[idx] of A and B plus the carry register; write the result into sum[idx*16 +: 16]; update the carry register; increment idx.
REQ-022 On the edge that writes slice SLICES-1, the block SHALL: load cout, flag_s, flag_z, flag_p and flag_ov from the final sum and carry; enter DONE.
REQ-023 Latency SHALL be exactly SLICES edges (4) from the start-accepting edge to done=1; done SHALL be high only while in DONE.
REQ-024 busy SHALL equal (state == RUN); busy and done SHALL never be high together.
REQ-025 start while busy=1 SHALL be ignored, with no effect on operands, idx or outputs.
REQ-026 Changes on a, b or cin after the accepting edge SHALL NOT affect the result in progress.
REQ-027 Carry SHALL propagate between slices only through the carry register; there SHALL be no combinational path from a, b or cin to any output.
REQ-028 flag_ov SHALL be (A[63] == B[63]) && (sum[63] != A[63]), using the latched operands.
REQ-029 Arithmetic SHALL be modulo 2^64; the carry beyond bit 63 SHALL appear only on cout.
REQ-030 sum is partial during RUN; sum and all flags SHALL hold their values from DONE until the next accepting edge.
REQ-031 Back-to-back operation: start=1 while in DONE SHALL be accepted on that edge, so done is low for the following cycle.
REQ-032 The SLICES*SLICE_W = 64 arithmetic SHALL hold for the default parameters, with idx width = clog2(SLICES).

Reset
REQ-033 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, sum=0, cout=0, carry register=0, idx=0, flag_s=0, flag_z=0, flag_p=0 and flag_ov=0.
REQ-034 Reset asserted during RUN SHALL abort the operation; no done pulse SHALL follow.
REQ-035 After rst_n deasserts, the first start SHALL be accepted normally.

Verification
REQ-036 a=0x1, b=0x1, cin=0 -> after 4 cycles: done=1, sum=0x2, cout=0, S=0, Z=0, P=0, OV=0.
REQ-037 a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, cin=0 -> sum=0, cout=1, Z=1, P=1, S=0, OV=0; the carry ripples through all 4 slices.
REQ-038 a=0x8000_0000_0000_0000, b=0x8000_0000_0000_0000 -> sum=0, cout=1, Z=1, P=1, OV=1.
REQ-039 a=0x0000_0000_0000_FFFF, b=0x0, cin=1 -> sum=0x10000, cout=0, P=0; proves the carry crosses the slice 0 to slice 1 boundary.
REQ-040 start pulsed again in the 2nd RUN cycle with different operands -> ignored; the result matches the first operands and done occurs 4 cycles after the first start.
REQ-041 rst_n pulsed low during the 3rd RUN cycle -> all outputs are 0 immediately and no done pulse follows; a new start afterwards completes correctly.

Source files
------------

// File: rtl/add_sequencer.sv
// Multi-cycle adder: one SLICE_W-bit adder is time-shared over SLICES slices, with the carry
// rippling between slices through a register. Results and flags are registered on the last slice.
module add_sequencer #(
  parameter int unsigned SLICE_W = 16,
  parameter int unsigned SLICES  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [SLICE_W*SLICES-1:0]  a,
  input  logic [SLICE_W*SLICES-1:0]  b,
  input  logic                       cin,
  output logic [SLICE_W*SLICES-1:0]  sum,
  output logic                       cout,
  output logic                       flag_s,
  output logic                       flag_z,
  output logic                       flag_p,
  output logic                       flag_ov,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned Width = SLICE_W * SLICES;
  localparam int unsigned IdxW  = (SLICES > 1) ? $clog2(SLICES) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic [IdxW-1:0]   idx_q;
  logic              carry_q;
  logic [Width-1:0]  a_q;
  logic [Width-1:0]  b_q;

  logic [SLICE_W-1:0] add_a;
  logic [SLICE_W-1:0] add_b;
  logic [SLICE_W-1:0] add_s;
  logic               add_c;
  logic [Width-1:0]   sum_next;
  logic               last_slice;

  // Slice select with constant part-selects keeps the mux explicit and width-exact.
  always_comb begin
    add_a = '0;
    add_b = '0;
    for (int unsigned i = 0; i < SLICES; i++) begin
      if (idx_q == IdxW'(i)) begin
        add_a = a_q[i*SLICE_W +: SLICE_W];
        add_b = b_q[i*SLICE_W +: SLICE_W];
      end
    end
  end

  // The single shared adder.
  assign {add_c, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{SLICE_W{1'b0}}, carry_q};

  always_comb begin
    sum_next = sum;
    for (int unsigned i = 0; i < SLICES; i++) begin
      if (idx_q == IdxW'(i)) begin
        sum_next[i*SLICE_W +: SLICE_W] = add_s;
      end
    end
  end

  assign last_slice = (idx_q == IdxW'(SLICES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      flag_s  <= 1'b0;
      flag_z  <= 1'b0;
      flag_p  <= 1'b0;
      flag_ov <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
            state_q <= StRun;
            busy    <= 1'b1;
          end else begin
            state_q <= StIdle;
          end
          done <= 1'b0;
        end
        StRun: begin
          sum     <= sum_next;
          carry_q <= add_c;
          idx_q   <= idx_q + 1'b1;
          if (last_slice) begin
            cout    <= add_c;
            flag_s  <= sum_next[Width-1];
            flag_z  <= (sum_next == '0);
            flag_p  <= ~^sum_next;
            flag_ov <= (a_q[Width-1] == b_q[Width-1]) && (sum_next[Width-1] != a_q[Width-1]);
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_sequencer.sv
// Bench for add_sequencer: directed corner cases plus randomized operations compared against
// a plain 65-bit arithmetic reference model.
module tb_add_sequencer;

  localparam int unsigned SliceW = 16;
  localparam int unsigned Slices = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        cin   = 1'b0;
  logic [63:0] a     = '0;
  logic [63:0] b     = '0;
  logic [63:0] sum;
  logic        cout, flag_s, flag_z, flag_p, flag_ov, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  add_sequencer #(
    .SLICE_W(SliceW),
    .SLICES (Slices)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .sum    (sum),
    .cout   (cout),
    .flag_s (flag_s),
    .flag_z (flag_z),
    .flag_p (flag_p),
    .flag_ov(flag_ov),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, ".sum"}, sum, 64'd0);
    check_val({tag, ".cout"}, {63'd0, cout}, 64'd0);
    check_val({tag, ".flags"}, {60'd0, flag_s, flag_z, flag_p, flag_ov}, 64'd0);
    check_val({tag, ".busy"}, {63'd0, busy}, 64'd0);
    check_val({tag, ".done"}, {63'd0, done}, 64'd0);
  endtask

  // Reference: full-width addition, flags derived from the definitions.
  task automatic expect_result(input string tag, input logic [63:0] ea, input logic [63:0] eb,
                               input logic ec);
    logic [64:0] full;
    logic [63:0] es;
    logic        ep;
    logic        eov;
    full = {1'b0, ea} + {1'b0, eb} + {64'd0, ec};
    es   = full[63:0];
    ep   = 1'b1;
    for (int i = 0; i < 64; i++) if (es[i]) ep = ~ep;
    eov  = (ea[63] == eb[63]) && (es[63] != ea[63]);
    check_val({tag, ".done"}, {63'd0, done}, 64'd1);
    check_val({tag, ".busy"}, {63'd0, busy}, 64'd0);
    check_val({tag, ".sum"}, sum, es);
    check_val({tag, ".cout"}, {63'd0, cout}, {63'd0, full[64]});
    check_val({tag, ".szpo"}, {60'd0, flag_s, flag_z, flag_p, flag_ov},
              {60'd0, es[63], (es == 64'd0), ep, eov});
  endtask

  // Presents operands with start for one edge, then scrambles the inputs.
  task automatic launch(input logic [63:0] ta, input logic [63:0] tb, input logic tc);
    @(negedge clk);
    a = ta;
    b = tb;
    cin = tc;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    cin = 1'($urandom_range(0, 1));
  endtask

  // Expects busy for exactly `n` edges, leaving the bench #1 after the last one.
  task automatic run_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check_val({tag, ".run_busy"}, {62'd0, busy, done}, 64'd2);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_hold(input string tag, input logic [63:0] held);
    @(posedge clk);
    #1;
    check_val({tag, ".hold_done"}, {62'd0, busy, done}, 64'd0);
    check_val({tag, ".hold_sum"}, sum, held);
  endtask

  task automatic directed(input string tag, input logic [63:0] ta, input logic [63:0] tb,
                          input logic tc);
    logic [63:0] exp_sum;
    exp_sum = ta + tb + {63'd0, tc};
    launch(ta, tb, tc);
    run_cycles(tag, Slices);
    expect_result(tag, ta, tb, tc);
    idle_hold(tag, exp_sum);
  endtask

  initial begin
    logic [63:0] ra, rb, a1, b1;
    logic        rc, c1;

    #1 rst_n = 1'b0;
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    directed("one_plus_one", 64'h1, 64'h1, 1'b0);
    directed("ripple_all", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    directed("neg_overflow", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
    directed("slice_carry", 64'h0000_0000_0000_FFFF, 64'h0, 1'b1);
    directed("pos_overflow", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);

    // start during RUN is ignored; done still lands Slices edges after the first start
    a1 = 64'h0123_4567_89AB_CDEF;
    b1 = 64'h1111_2222_3333_4444;
    c1 = 1'b1;
    launch(a1, b1, c1);
    run_cycles("ignore", 1);
    a = 64'hDEAD_BEEF_0000_0001;
    b = 64'hFFFF_0000_FFFF_0000;
    cin = 1'b0;
    start = 1'b1;
    check_val("ignore.run_busy2", {62'd0, busy, done}, 64'd2);
    @(posedge clk);
    #1;
    start = 1'b0;
    run_cycles("ignore", Slices - 2);
    expect_result("ignore", a1, b1, c1);
    idle_hold("ignore", a1 + b1 + 64'd1);

    // reset mid-operation aborts with no done afterwards
    launch(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    run_cycles("abort", 2);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check_val("abort.no_done", {62'd0, busy, done}, 64'd0);
    end
    directed("after_reset", 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0);

    // Randomized; back-to-back starts are issued directly from DONE.
    for (int k = 0; k < 40; k++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: rb = ~ra;
        1: ra = 64'hFFFF_FFFF_FFFF_FFFF;
        2: rb = 64'd0 - ra - {63'd0, rc};
        default: ;
      endcase
      launch(ra, rb, rc);
      run_cycles("rand", Slices);
      expect_result("rand", ra, rb, rc);
      if ($urandom_range(0, 1) == 1) idle_hold("rand", ra + rb + {63'd0, rc});
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
